qpel_avg_sched: RTL and testbench

//  Sequences the FME quarter-pel averaging datapath over one BLK x BLK block.

---
 rtl/fme_pkg.sv | 16 +
 rtl/qpel_lane_avg.sv | 18 +
 rtl/qpel_avg_sched.sv | 156 +++++++++++++++
 tb/tb_qpel_avg_sched.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fme_pkg.sv
// rtl/fme_pkg.sv - shared FME encodings: averaging modes, scheduler states, pixel width
package fme_pkg;

  localparam int PIX_W_DEFAULT = 8;

  localparam logic [1:0] MODE_PASS_A = 2'b00;
  localparam logic [1:0] MODE_PASS_B = 2'b01;
  localparam logic [1:0] MODE_AVG    = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/qpel_lane_avg.sv
// rtl/qpel_lane_avg.sv - single-lane rounding average (a + b + 1) >> 1
module qpel_lane_avg
  import fme_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEFAULT
) (
  input  logic [PIX_W-1:0] a,
  input  logic [PIX_W-1:0] b,
  output logic [PIX_W-1:0] avg
);

  // One extra bit holds the carry; the shifted result always fits PIX_W.
  logic [PIX_W:0] sum;

  assign sum = {1'b0, a} + {1'b0, b} + {{PIX_W{1'b0}}, 1'b1};
  assign avg = PIX_W'(sum >> 1);

endmodule

// File: rtl/qpel_avg_sched.sv
// rtl/qpel_avg_sched.sv - quarter-pel averaging scheduler over a BLK x BLK block
// Optional QPEL_STALL_CNT_EN adds a saturating output-stall counter port.
module qpel_avg_sched
  import fme_pkg::*;
#(
  parameter int BLK   = 4,
  parameter int PIX_W = PIX_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         mode,
  output logic               busy,
  output logic               done,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLK*PIX_W-1:0] in_a,
  input  logic [BLK*PIX_W-1:0] in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLK*PIX_W-1:0] out_row,
  output logic               out_last
`ifdef QPEL_STALL_CNT_EN
  ,
  output logic [15:0]        stall_cnt
`endif
);

  localparam int ROW_W = BLK * PIX_W;
  localparam int CNT_W = $clog2(BLK);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(BLK - 1);

  state_e             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [CNT_W-1:0]   in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [ROW_W-1:0]   out_row_q, out_row_d;
  logic               done_q, done_d;

  logic               start_acc;
  logic               in_fire;
  logic               out_fire;
  logic [ROW_W-1:0]   res_row;

  for (genvar g = 0; g < BLK; g++) begin : g_lane
    logic [PIX_W-1:0] a_l, b_l, avg_l;

    assign a_l = in_a[g*PIX_W +: PIX_W];
    assign b_l = in_b[g*PIX_W +: PIX_W];

    qpel_lane_avg #(.PIX_W(PIX_W)) u_avg (
      .a   (a_l),
      .b   (b_l),
      .avg (avg_l)
    );

    assign res_row[g*PIX_W +: PIX_W] = (mode_q == MODE_PASS_A) ? a_l :
                                       (mode_q == MODE_PASS_B) ? b_l : avg_l;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN:   if (in_fire && (in_cnt_q == LAST_ROW)) state_d = ST_DRAIN;
      ST_DRAIN: if (out_fire && (out_cnt_q == LAST_ROW)) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Single output register with no skid: input only moves when the slot frees.
  always_comb begin
    busy      = (state_q != ST_IDLE);
    start_acc = (state_q == ST_IDLE) && start;
    in_ready  = (state_q == ST_RUN) && (!out_valid_q || out_ready);
    in_fire   = in_valid && in_ready;
    out_fire  = out_valid_q && out_ready;
    out_last  = out_valid_q && (out_cnt_q == LAST_ROW);
    out_valid = out_valid_q;
    out_row   = out_row_q;
    done      = done_q;
  end

  always_comb begin
    mode_d      = start_acc ? mode : mode_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    out_valid_d = out_valid_q;
    out_row_d   = out_row_q;
    done_d      = (state_q == ST_DRAIN) && out_fire && (out_cnt_q == LAST_ROW);
    if (start_acc) begin
      in_cnt_d  = '0;
      out_cnt_d = '0;
    end else begin
      if (in_fire)  in_cnt_d  = in_cnt_q + CNT_W'(1);
      if (out_fire) out_cnt_d = out_cnt_q + CNT_W'(1);
    end
    if (in_fire) begin
      out_valid_d = 1'b1;
      out_row_d   = res_row;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q      <= MODE_PASS_A;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      out_valid_q <= out_valid_d;
      out_row_q   <= out_row_d;
      done_q      <= done_d;
    end
  end

`ifdef QPEL_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (start_acc) begin
      stall_d = '0;
    end else if (out_valid_q && !out_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_qpel_avg_sched.sv
// tb/tb_qpel_avg_sched.sv - directed self-checking bench for qpel_avg_sched (BLK=4, PIX_W=8)
module tb_qpel_avg_sched;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  mode;
  logic        busy;
  logic        done;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_row;
  logic        out_last;
`ifdef QPEL_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int hs_cnt = 0;

  logic [31:0] ta [4];
  logic [31:0] tbv[4];
  logic [31:0] te [4];

  qpel_avg_sched #(.BLK(4), .PIX_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .busy      (busy),
    .done      (done),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_row   (out_row),
    .out_last  (out_last)
`ifdef QPEL_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) hs_cnt <= hs_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One block: mode m, optional stall of the first output row; start and mode
  // are deliberately disturbed while the block runs.
  task automatic run_block(input logic [1:0] m, input int stall);
    int hs0;
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
`ifdef QPEL_STALL_CNT_EN
    check("stall_cnt_cleared", stall_cnt, 0);
`endif
    hs0  = hs_cnt;
    mode = m ^ 2'b10;
    for (int r = 0; r < 4; r++) begin
      start    = 1'b1;
      in_valid = 1'b1;
      in_a     = ta[r];
      in_b     = tbv[r];
      if (r == 1 && stall > 0) begin
        out_ready = 1'b0;
        #1 check("in_ready_stalled", in_ready, 0);
        for (int k = 0; k < stall; k++) begin
          @(negedge clk);
          check("stall_out_valid", out_valid, 1);
          check("stall_out_row", out_row, te[0]);
          check("stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
      end
      #1 check("in_ready_run", in_ready, 1);
      @(negedge clk);
      check("out_valid", out_valid, 1);
      check("out_row", out_row, te[r]);
      check("out_last", out_last, (r == 3) ? 1 : 0);
    end
    start    = 1'b0;
    in_valid = 1'b0;
    #1 check("in_ready_drain", in_ready, 0);
    @(negedge clk);
    check("done_pulse", done, 1);
    check("busy_at_done", busy, 0);
    check("out_valid_at_done", out_valid, 0);
    check("handshakes", hs_cnt - hs0, 4);
`ifdef QPEL_STALL_CNT_EN
    check("stall_cnt_at_done", stall_cnt, stall);
`endif
    @(negedge clk);
    check("done_cleared", done, 0);
    check("busy_idle", busy, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b1;
    mode      = 2'b10;
    in_valid  = 1'b1;
    in_a      = 32'h0;
    in_b      = 32'h0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_row", out_row, 0);
    check("rst_out_last", out_last, 0);
    rst_n    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;

    // Averaging with rounding
    ta[0] = 32'hFFFE0100; tbv[0] = 32'hFFFF0101; te[0] = 32'hFFFF0101;
    ta[1] = 32'h00000000; tbv[1] = 32'h01010101; te[1] = 32'h01010101;
    ta[2] = 32'h10203040; tbv[2] = 32'h30405060; te[2] = 32'h20304050;
    ta[3] = 32'h03020100; tbv[3] = 32'h00000000; te[3] = 32'h02010100;
    run_block(2'b10, 0);
    run_block(2'b11, 0);

    // Pass modes
    for (int r = 0; r < 4; r++) begin
      ta[r] = 32'h10203040; tbv[r] = 32'hFFFFFFFF; te[r] = 32'h10203040;
    end
    run_block(2'b00, 0);
    for (int r = 0; r < 4; r++) te[r] = 32'hFFFFFFFF;
    run_block(2'b01, 0);

    // Backpressure
    ta[0] = 32'hFFFE0100; tbv[0] = 32'hFFFF0101; te[0] = 32'hFFFF0101;
    ta[1] = 32'h00000000; tbv[1] = 32'h01010101; te[1] = 32'h01010101;
    ta[2] = 32'h10203040; tbv[2] = 32'h30405060; te[2] = 32'h20304050;
    ta[3] = 32'h03020100; tbv[3] = 32'h00000000; te[3] = 32'h02010100;
    run_block(2'b10, 4);

    // Reset mid-block after two rows
    @(negedge clk);
    start = 1'b1;
    mode  = 2'b10;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    in_a     = ta[0];
    in_b     = tbv[0];
    @(negedge clk);
    in_a = ta[1];
    in_b = tbv[1];
    @(negedge clk);
    check("mid_out_row", out_row, te[1]);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_row", out_row, 0);
    check("midrst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    run_block(2'b10, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
